// File: rtl/lsb_queue.sv
// lsb_queue: in-order load/store buffer between dispatch, ROB, the two CDB
// channels and the memory controller. Each slot lives in an lsb_entry
// instance that owns its own operand snoop and commit tracking. The queue
// top owns the pointers, the issue FSM and the registered memory/result ports.

// One buffer slot. It captures a dispatched op, resolves operands from either
// CDB (including same-cycle bypass at dispatch) and tracks commit/st_rdy state.
module lsb_entry #(
    parameter int TAG_W = 4,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             wr,
    input  logic             clr,
    input  logic             set_sent,
    input  logic             d_is_store,
    input  logic [2:0]       d_funct3,
    input  logic [XLEN-1:0]  d_vj,
    input  logic [XLEN-1:0]  d_vk,
    input  logic [XLEN-1:0]  d_imm,
    input  logic [TAG_W-1:0] d_qj,
    input  logic [TAG_W-1:0] d_qk,
    input  logic [TAG_W-1:0] d_dest,
    input  logic             cdb0_valid,
    input  logic [TAG_W-1:0] cdb0_tag,
    input  logic [XLEN-1:0]  cdb0_data,
    input  logic             cdb1_valid,
    input  logic [TAG_W-1:0] cdb1_tag,
    input  logic [XLEN-1:0]  cdb1_data,
    input  logic             commit_valid,
    input  logic [TAG_W-1:0] commit_tag,
    output logic             valid,
    output logic             is_store,
    output logic [2:0]       funct3,
    output logic [XLEN-1:0]  vj,
    output logic [XLEN-1:0]  vk,
    output logic [XLEN-1:0]  imm,
    output logic [TAG_W-1:0] qj,
    output logic [TAG_W-1:0] qk,
    output logic [TAG_W-1:0] dest,
    output logic             committed,
    output logic             sent
);
    logic [TAG_W-1:0] src_qj, src_qk, nx_qj, nx_qk;
    logic [XLEN-1:0]  src_vj, src_vk, nx_vj, nx_vk;

    // Operand source is the dispatch bus on a write, else the held value;
    // either way a matching CDB resolves it. cdb0 wins a (never expected) tie.
    always_comb begin
        src_qj = wr ? d_qj : qj;
        src_vj = wr ? d_vj : vj;
        src_qk = wr ? d_qk : qk;
        src_vk = wr ? d_vk : vk;
        nx_qj  = src_qj;
        nx_vj  = src_vj;
        nx_qk  = src_qk;
        nx_vk  = src_vk;
        if (src_qj != '0) begin
            if (cdb0_valid && cdb0_tag == src_qj) begin
                nx_qj = '0;
                nx_vj = cdb0_data;
            end else if (cdb1_valid && cdb1_tag == src_qj) begin
                nx_qj = '0;
                nx_vj = cdb1_data;
            end
        end
        if (src_qk != '0) begin
            if (cdb0_valid && cdb0_tag == src_qk) begin
                nx_qk = '0;
                nx_vk = cdb0_data;
            end else if (cdb1_valid && cdb1_tag == src_qk) begin
                nx_qk = '0;
                nx_vk = cdb1_data;
            end
        end
    end

    // Slot state: clear beats write beats in-place snoop/commit updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid     <= 1'b0;
            is_store  <= 1'b0;
            funct3    <= '0;
            vj        <= '0;
            vk        <= '0;
            imm       <= '0;
            qj        <= '0;
            qk        <= '0;
            dest      <= '0;
            committed <= 1'b0;
            sent      <= 1'b0;
        end else if (rdy) begin
            if (clr) begin
                valid     <= 1'b0;
                committed <= 1'b0;
                sent      <= 1'b0;
            end else if (wr) begin
                valid     <= 1'b1;
                is_store  <= d_is_store;
                funct3    <= d_funct3;
                imm       <= d_imm;
                dest      <= d_dest;
                qj        <= nx_qj;
                vj        <= nx_vj;
                qk        <= nx_qk;
                vk        <= nx_vk;
                committed <= 1'b0;
                sent      <= 1'b0;
            end else if (valid) begin
                qj <= nx_qj;
                vj <= nx_vj;
                qk <= nx_qk;
                vk <= nx_vk;
                if (commit_valid && commit_tag == dest) committed <= 1'b1;
                if (set_sent) sent <= 1'b1;
            end
        end
    end
endmodule

module lsb_queue #(
    parameter int DEPTH_LOG = 3,
    parameter int TAG_W     = 4,
    parameter int XLEN      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_is_store,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_vj,
    input  logic [XLEN-1:0]  in_vk,
    input  logic [TAG_W-1:0] in_qj,
    input  logic [TAG_W-1:0] in_qk,
    input  logic [TAG_W-1:0] in_dest,
    input  logic [XLEN-1:0]  in_imm,
    output logic             full,
    input  logic             cdb0_valid,
    input  logic [TAG_W-1:0] cdb0_tag,
    input  logic [XLEN-1:0]  cdb0_data,
    input  logic             cdb1_valid,
    input  logic [TAG_W-1:0] cdb1_tag,
    input  logic [XLEN-1:0]  cdb1_data,
    input  logic             commit_valid,
    input  logic [TAG_W-1:0] commit_tag,
    output logic             st_rdy_valid,
    output logic [TAG_W-1:0] st_rdy_tag,
    output logic             ld_valid,
    output logic [TAG_W-1:0] ld_tag,
    output logic [XLEN-1:0]  ld_data,
    output logic             mem_req,
    output logic             mem_we,
    output logic [XLEN-1:0]  mem_addr,
    output logic [2:0]       mem_len,
    output logic [XLEN-1:0]  mem_wdata,
    input  logic             mem_done,
    input  logic [XLEN-1:0]  mem_rdata
);
    localparam int DEPTH = 2 ** DEPTH_LOG;
    localparam int CW    = DEPTH_LOG + 1;

    typedef struct packed {
        logic             is_store;
        logic [2:0]       funct3;
        logic [XLEN-1:0]  vj;
        logic [XLEN-1:0]  vk;
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] qj;
        logic [TAG_W-1:0] qk;
        logic [TAG_W-1:0] dest;
        logic             committed;
        logic             sent;
    } ent_t;

    typedef enum logic [1:0] {IDLE, LOAD_WAIT, STORE_WAIT, LOAD_DRAIN} state_t;

    state_t                 state, state_nx;
    logic [DEPTH_LOG-1:0]   head, tail;
    logic [CW-1:0]          count, kept;
    ent_t [DEPTH-1:0]       ent;
    logic [DEPTH-1:0]       ent_vld, ent_clr;
    ent_t                   hd;
    logic                   hd_rdy, accept, load_busy;
    logic                   pop, iss_ld, iss_st, pulse_st, ld_fire, mem_fin;
    logic [XLEN-1:0]        ld_ext;

    assign full      = (count >= CW'(DEPTH - 1));
    assign accept    = in_valid && (count < CW'(DEPTH)) && !flush;
    assign hd        = ent[head];
    assign hd_rdy    = ent_vld[head] && (hd.qj == '0) && (hd.qk == '0);
    assign load_busy = (state == LOAD_WAIT) || (state == LOAD_DRAIN);

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic             e_is_store, e_committed, e_sent;
        logic [2:0]       e_funct3;
        logic [XLEN-1:0]  e_vj, e_vk, e_imm;
        logic [TAG_W-1:0] e_qj, e_qk, e_dest;

        lsb_entry #(.TAG_W(TAG_W), .XLEN(XLEN)) u_ent (
            .clk          (clk),
            .rst          (rst),
            .rdy          (rdy),
            .wr           (accept && (tail == DEPTH_LOG'(i))),
            .clr          (ent_clr[i]),
            .set_sent     (pulse_st && (head == DEPTH_LOG'(i))),
            .d_is_store   (in_is_store),
            .d_funct3     (in_funct3),
            .d_vj         (in_vj),
            .d_vk         (in_vk),
            .d_imm        (in_imm),
            .d_qj         (in_qj),
            .d_qk         (in_qk),
            .d_dest       (in_dest),
            .cdb0_valid   (cdb0_valid),
            .cdb0_tag     (cdb0_tag),
            .cdb0_data    (cdb0_data),
            .cdb1_valid   (cdb1_valid),
            .cdb1_tag     (cdb1_tag),
            .cdb1_data    (cdb1_data),
            .commit_valid (commit_valid),
            .commit_tag   (commit_tag),
            .valid        (ent_vld[i]),
            .is_store     (e_is_store),
            .funct3       (e_funct3),
            .vj           (e_vj),
            .vk           (e_vk),
            .imm          (e_imm),
            .qj           (e_qj),
            .qk           (e_qk),
            .dest         (e_dest),
            .committed    (e_committed),
            .sent         (e_sent)
        );

        assign ent[i] = '{is_store: e_is_store, funct3: e_funct3, vj: e_vj, vk: e_vk,
                          imm: e_imm, qj: e_qj, qk: e_qk, dest: e_dest,
                          committed: e_committed, sent: e_sent};
    end

    // Entries surviving a flush: committed stores plus an in-flight head load
    // (it stays until its memory access drains). Slots leave on pop or flush.
    always_comb begin
        kept = load_busy ? CW'(1) : CW'(0);
        for (int i = 0; i < DEPTH; i++) begin
            kept += CW'(ent_vld[i] && ent[i].committed);
        end
        for (int i = 0; i < DEPTH; i++) begin
            ent_clr[i] = (pop && head == DEPTH_LOG'(i)) ||
                         (flush && !(ent[i].committed || (load_busy && head == DEPTH_LOG'(i))));
        end
    end

    // Issue FSM next-state and control strobes; nothing issues on a flush cycle.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        iss_ld   = 1'b0;
        iss_st   = 1'b0;
        pulse_st = 1'b0;
        ld_fire  = 1'b0;
        mem_fin  = 1'b0;
        case (state)
            IDLE: begin
                if (!flush && hd_rdy) begin
                    if (!hd.is_store) begin
                        iss_ld   = 1'b1;
                        state_nx = LOAD_WAIT;
                    end else if (hd.committed) begin
                        iss_st   = 1'b1;
                        state_nx = STORE_WAIT;
                    end else if (!hd.sent) begin
                        pulse_st = 1'b1;
                    end
                end
            end
            LOAD_WAIT: begin
                if (mem_done) begin
                    pop      = 1'b1;
                    mem_fin  = 1'b1;
                    ld_fire  = !flush;
                    state_nx = IDLE;
                end else if (flush) begin
                    state_nx = LOAD_DRAIN;
                end
            end
            STORE_WAIT, LOAD_DRAIN: begin
                if (mem_done) begin
                    pop      = 1'b1;
                    mem_fin  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Width-extend raw read data by the head load's funct3.
    always_comb begin
        case (hd.funct3)
            3'b000:  ld_ext = {{(XLEN-8){mem_rdata[7]}}, mem_rdata[7:0]};
            3'b001:  ld_ext = {{(XLEN-16){mem_rdata[15]}}, mem_rdata[15:0]};
            3'b100:  ld_ext = {{(XLEN-8){1'b0}}, mem_rdata[7:0]};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}}, mem_rdata[15:0]};
            default: ld_ext = mem_rdata;
        endcase
    end

    // FSM state register, frozen while rdy is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      state <= IDLE;
        else if (rdy) state <= state_nx;
    end

    // Queue pointers; a flush rebuilds tail/count from the surviving prefix.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            head <= head + DEPTH_LOG'(pop);
            if (flush) begin
                tail  <= head + kept[DEPTH_LOG-1:0];
                count <= kept - CW'(pop);
            end else begin
                tail  <= tail + DEPTH_LOG'(accept);
                count <= count + CW'(accept) - CW'(pop);
            end
        end
    end

    // Registered memory, st_rdy and load-result ports; pulses self-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_rdy_valid <= 1'b0;
            st_rdy_tag   <= '0;
            ld_valid     <= 1'b0;
            ld_tag       <= '0;
            ld_data      <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_len      <= '0;
            mem_wdata    <= '0;
        end else if (rdy) begin
            st_rdy_valid <= 1'b0;
            ld_valid     <= 1'b0;
            if (pulse_st) begin
                st_rdy_valid <= 1'b1;
                st_rdy_tag   <= hd.dest;
            end
            if (ld_fire) begin
                ld_valid <= 1'b1;
                ld_tag   <= hd.dest;
                ld_data  <= ld_ext;
            end
            if (mem_fin) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end
            if (iss_ld || iss_st) begin
                mem_req   <= 1'b1;
                mem_we    <= iss_st;
                mem_addr  <= hd.vj + hd.imm;
                mem_wdata <= iss_st ? hd.vk : '0;
                case (hd.funct3[1:0])
                    2'b00:   mem_len <= 3'd1;
                    2'b01:   mem_len <= 3'd2;
                    default: mem_len <= 3'd4;
                endcase
            end
        end
    end
endmodule
